uart_bus_responder: RTL

Synthesizable UART device that answers the CPU-side UART strobe interface (rdn/wrn, dataready/tbre/tsre) issued by the memory-mapped I/O path at 0xBFD003F8/0xBFD003FC. It replaces the off-chip UART controller with on-chip serialisation. Parallel side: one-byte transmit holding register, one-byte receive buffer, status flags. Serial side: 8N1 asynchronous txd/rxd.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sampler.sv | 96 +++++++++
 rtl/uart_bus_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the on-chip UART responder.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Clocks per serial bit; integer division, caller must keep the result >= 4.
  function automatic int unsigned calc_div(int unsigned clk_freq, int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// 8N1 receiver: synchroniser, start-bit qualification, mid-bit sampling, stop check.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_byte_o,
  output logic                 rx_valid_o
);

  localparam int unsigned CntW = $clog2(DIV) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(DIV / 2 - 1);
  localparam logic [2:0] BitLast = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic                 fall;

  // s3 is only used for edge detection; s2 is the sampled line value.
  assign fall      = rxd_s3_q & ~rxd_s2_q;
  assign rx_byte_o = shift_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_valid_o = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (fall) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Line back high at mid start bit is a glitch, not a frame.
          state_d   = rxd_s2_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          shift_d   = {rxd_s2_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BitLast) state_d = RxStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == CntLast) begin
          cnt_d      = '0;
          rx_valid_o = rxd_s2_q;
          state_d    = RxIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rxd_s1_q  <= 1'b1;
      rxd_s2_q  <= 1'b1;
      rxd_s3_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rxd_s1_q  <= rxd_i;
      rxd_s2_q  <= rxd_s1_q;
      rxd_s3_q  <= rxd_s2_q;
    end
  end

endmodule

// File: rtl/uart_bus_responder.sv
// UART device behind the CPU rdn/wrn strobe interface: THR + TX serialiser,
// receive buffer and status flags.
module uart_bus_responder
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       dataready,
  output logic       tbre,
  output logic       tsre,
  output logic       overrun,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CntW = $clog2(DIV) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [2:0] BitLast = 3'(DATA_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_BITS-1:0] thr_q, thr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
  logic                 dataready_q, dataready_d, overrun_q, overrun_d;
  logic                 rdn_q, wrn_q;
  logic                 wr_commit, rd_commit, tx_load;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_valid;

  uart_rx_sampler #(
    .DIV(DIV)
  ) u_rx (
    .clk_i      (clk),
    .rst_i      (rst),
    .rxd_i      (rxd),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid)
  );

  // Commit on the end of a strobe; a write overlapping a read suppresses the read.
  assign wr_commit = ~wrn_q & wrn;
  assign rd_commit = ~rdn_q & rdn & wrn_q;

  assign data_oe   = ~rdn;
  assign data_out  = data_out_q;
  assign dataready = dataready_q;
  assign tbre      = tbre_q;
  assign tsre      = tsre_q;
  assign overrun   = overrun_q;
  assign txd       = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;

    if (wr_commit && tbre_q) begin
      thr_d  = data_in;
      tbre_d = 1'b0;
    end

    unique case (tx_state_q)
      TxIdle: tx_load = ~tbre_q;
      TxStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BitLast) begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          // A pending THR byte chains straight into the next start bit.
          if (!tbre_q) begin
            tx_load = 1'b1;
          end else begin
            tx_state_d = TxIdle;
            tsre_d     = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase

    if (tx_load) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_shift_d = thr_q;
      tbre_d     = 1'b1;
      tsre_d     = 1'b0;
      txd_d      = 1'b0;
    end
  end

  always_comb begin
    data_out_d  = data_out_q;
    dataready_d = dataready_q;
    overrun_d   = overrun_q;
    if (rd_commit) begin
      dataready_d = 1'b0;
      overrun_d   = 1'b0;
    end
    // A store in the same clk as a read wins and does not count as overrun.
    if (rx_valid) begin
      data_out_d  = rx_byte;
      dataready_d = 1'b1;
      if (dataready_q && !rd_commit) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      thr_q       <= '0;
      tbre_q      <= 1'b1;
      tsre_q      <= 1'b1;
      txd_q       <= 1'b1;
      data_out_q  <= '0;
      dataready_q <= 1'b0;
      overrun_q   <= 1'b0;
      rdn_q       <= 1'b1;
      wrn_q       <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      thr_q       <= thr_d;
      tbre_q      <= tbre_d;
      tsre_q      <= tsre_d;
      txd_q       <= txd_d;
      data_out_q  <= data_out_d;
      dataready_q <= dataready_d;
      overrun_q   <= overrun_d;
      rdn_q       <= rdn;
      wrn_q       <= wrn;
    end
  end

endmodule
